// File: rtl/pwm_pkg.sv
// Constants and state type shared by the ramp sequencer and the PWM generator.
package pwm_pkg;

   localparam int PWM_PERIOD = 100;
   localparam int PWM_DUTY_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RAMP,
      HOLD,
      STOP
   } ramp_state_e;

endpackage

// File: rtl/pwm_period_cnt.sv
// Free-running period counter with a registered end-of-period tick.
module pwm_period_cnt #(
   parameter int PERIOD = 100,
   parameter int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   output logic [CNT_W-1:0] pcnt_o,
   output logic             period_tick_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic             tick_q;

   always_comb begin
      pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + 1'b1;
   end

   // The tick is registered from the next count so it is high exactly while pcnt == PERIOD-1.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pcnt_q <= '0;
         tick_q <= 1'b0;
      end else begin
         pcnt_q <= pcnt_d;
         tick_q <= (pcnt_d == LAST);
      end
   end

   assign pcnt_o        = pcnt_q;
   assign period_tick_o = tick_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / soft-stop duty sequencer; duty moves only on period boundaries.
module pwm_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int PERIOD = PWM_PERIOD,
   parameter int DUTY_W = PWM_DUTY_W,
   parameter int STEP_W = 4,
   parameter int IVL_W  = 8
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              enable,
   input  logic              load,
   input  logic [DUTY_W-1:0] target,
   input  logic [STEP_W-1:0] step,
   input  logic [IVL_W-1:0]  interval,
   output logic [DUTY_W-1:0] duty,
   output logic              period_tick,
   output logic              busy,
   output logic              done
);

   localparam int                CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

   ramp_state_e       state_q;
   logic [DUTY_W-1:0] duty_q, tgt_s_q, tgt_s_d, duty_ramp, duty_stop;
   logic [STEP_W-1:0] step_s_q, step_s_d;
   logic [IVL_W-1:0]  ivl_s_q, ivl_s_d, ivl_cnt_q, ivl_cnt_d;
   logic              busy_q, done_q, tick, ivl_last, upd;
   logic [CNT_W-1:0]  pcnt_unused;

   function automatic logic [DUTY_W-1:0] step_up(input logic [DUTY_W-1:0] d,
                                                 input logic [DUTY_W-1:0] t,
                                                 input logic [STEP_W-1:0] s);
      logic [DUTY_W:0] sum;
      sum = {1'b0, d} + (DUTY_W + 1)'(s);
      return (sum > {1'b0, t}) ? t : sum[DUTY_W-1:0];
   endfunction

   function automatic logic [DUTY_W-1:0] step_down(input logic [DUTY_W-1:0] d,
                                                   input logic [DUTY_W-1:0] t,
                                                   input logic [STEP_W-1:0] s);
      logic [DUTY_W:0] lim;
      lim = {1'b0, t} + (DUTY_W + 1)'(s);
      return ({1'b0, d} > lim) ? d - DUTY_W'(s) : t;
   endfunction

   // pcnt is exported for aligning the PWM generator; the sequencer only needs the tick.
   pwm_period_cnt #(
      .PERIOD (PERIOD),
      .CNT_W  (CNT_W)
   ) u_period_cnt (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .pcnt_o        (pcnt_unused),
      .period_tick_o (tick)
   );

   always_comb begin
      tgt_s_d   = (target > DUTY_MAX) ? DUTY_MAX : target;
      step_s_d  = (step == '0) ? STEP_W'(1) : step;
      ivl_s_d   = (interval == '0) ? IVL_W'(1) : interval;
      ivl_last  = (ivl_cnt_q == ivl_s_q - IVL_W'(1));
      // A load restarts the interval, so it also swallows a coincident update.
      upd       = tick && !load && ivl_last;
      ivl_cnt_d = ivl_cnt_q;
      if (load) begin
         ivl_cnt_d = '0;
      end else if (tick) begin
         ivl_cnt_d = ivl_last ? '0 : ivl_cnt_q + IVL_W'(1);
      end
      duty_ramp = (duty_q < tgt_s_q) ? step_up(duty_q, tgt_s_q, step_s_q)
                                     : step_down(duty_q, tgt_s_q, step_s_q);
      duty_stop = step_down(duty_q, '0, step_s_q);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         duty_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tgt_s_q   <= '0;
         step_s_q  <= '0;
         ivl_s_q   <= '0;
         ivl_cnt_q <= '0;
      end else begin
         done_q    <= 1'b0;
         ivl_cnt_q <= ivl_cnt_d;
         if (load) begin
            tgt_s_q  <= tgt_s_d;
            step_s_q <= step_s_d;
            ivl_s_q  <= ivl_s_d;
         end
         unique case (state_q)
            IDLE: begin
               if (!enable) begin
                  if (duty_q != '0) begin
                     state_q <= STOP;
                     busy_q  <= 1'b1;
                  end
               end else if (load) begin
                  state_q <= RAMP;
                  busy_q  <= 1'b1;
               end
            end
            RAMP: begin
               if (!enable) begin
                  state_q <= STOP;
               end else if (upd) begin
                  duty_q <= duty_ramp;
                  if (duty_ramp == tgt_s_q) begin
                     state_q <= HOLD;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (!enable) begin
                  state_q <= STOP;
                  busy_q  <= 1'b1;
               end else if (load) begin
                  state_q <= RAMP;
                  busy_q  <= 1'b1;
               end
            end
            STOP: begin
               if (enable && load) begin
                  state_q <= RAMP;
               end else if (upd) begin
                  duty_q <= duty_stop;
                  if (duty_stop == '0) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign duty        = duty_q;
   assign period_tick = tick;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
